// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and ID-branch operand stalls, mul/div front-end freeze, branch flush.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rt,
    input  logic        id_branch,
    input  logic        id_taken,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_rd,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic        md_start,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        idex_we,
    output logic        exmem_bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lu_s;
    logic             br_ex_s;
    logic             br_mem_s;
    logic             hz_s;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Hazard detection terms.
    always_comb begin
        lu_s     = ex_memread && (reg_match(ex_rd, id_rs) || (id_use_rt && reg_match(ex_rd, id_rt)));
        br_ex_s  = id_branch && ex_regwrite && (reg_match(ex_rd, id_rs) || reg_match(ex_rd, id_rt));
        br_mem_s = id_branch && mem_memread && (reg_match(mem_rd, id_rs) || reg_match(mem_rd, id_rt));
        hz_s     = lu_s || br_ex_s || br_mem_s;
    end

    // Pipeline control outputs; mul/div freeze outranks hazards, hazards outrank the branch flush.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_we      = 1'b1;
        exmem_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        case (state_r)
            RUN: begin
                if (md_start) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    md_busy      = 1'b1;
                end else if (hz_s) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_taken) begin
                    ifid_flush = 1'b1;
                end else begin
                    pc_we = 1'b1;
                end
            end
            MD_WAIT: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                idex_we = 1'b0;
                md_busy = 1'b1;
                // On the final cycle the result is allowed through to MEM.
                if (cnt_r == CNT_ZERO) begin
                    md_done      = 1'b1;
                    exmem_bubble = 1'b0;
                end else begin
                    exmem_bubble = 1'b1;
                end
            end
            default: begin
                pc_we = 1'b1;
            end
        endcase
    end

    // Mul/div sequencing FSM and latency down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (md_start) begin
                        state_r <= MD_WAIT;
                        cnt_r   <= CNT_INIT;
                    end else begin
                        state_r <= RUN;
                        cnt_r   <= cnt_r;
                    end
                end
                MD_WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= RUN;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= MD_WAIT;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (!pc_we && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LATENCY=4.
module tb_hazard_ctrl;

    // Output vector order: pc_we ifid_we ifid_flush idex_flush idex_we exmem_bubble md_busy md_done
    localparam logic [7:0] O_IDLE  = 8'b1100_1000;
    localparam logic [7:0] O_HAZ   = 8'b0001_1000;
    localparam logic [7:0] O_TAKEN = 8'b1110_1000;
    localparam logic [7:0] O_MD    = 8'b0000_0110;
    localparam logic [7:0] O_DONE  = 8'b0000_0011;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rt;
    logic        id_branch;
    logic        id_taken;
    logic        ex_memread;
    logic        ex_regwrite;
    logic [4:0]  ex_rd;
    logic        mem_memread;
    logic [4:0]  mem_rd;
    logic        md_start;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        idex_we;
    logic        exmem_bubble;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_count;
    logic [7:0]  outs;

    int tests_run;
    int tests_failed;

    assign outs = {pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_bubble, md_busy, md_done};

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_taken(id_taken),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .md_start(md_start),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .idex_we(idex_we), .exmem_bubble(exmem_bubble),
        .md_busy(md_busy), .md_done(md_done), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1'b0; id_branch = 1'b0; id_taken = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        mem_memread = 1'b0; mem_rd = 5'd0; md_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        #4;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL reset_outs: got %b want %b", outs, O_IDLE);
        end
        tests_run++;
        if (stall_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_stall_count: got %0d want 0", stall_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #4;
        tests_run++;
        if (outs !== O_HAZ) begin
            tests_failed++;
            $display("FAIL lu_rs_stall: got %b want %b", outs, O_HAZ);
        end
        tick();
        clear_inputs();
        #4;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL lu_release: got %b want %b", outs, O_IDLE);
        end
        tick();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_use_rt = 1'b1;
        #4;
        tests_run++;
        if (outs !== O_HAZ) begin
            tests_failed++;
            $display("FAIL lu_rt_stall: got %b want %b", outs, O_HAZ);
        end
        tick();
        id_use_rt = 1'b0;
        #4;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL lu_rt_unused: got %b want %b", outs, O_IDLE);
        end
        tick();
        clear_inputs();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #4;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL lu_reg0: got %b want %b", outs, O_IDLE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        id_branch = 1'b1; id_rs = 5'd8; mem_memread = 1'b1; mem_rd = 5'd8; id_taken = 1'b1;
        #4;
        tests_run++;
        if (outs !== O_HAZ) begin
            tests_failed++;
            $display("FAIL br_mem_stall: got %b want %b", outs, O_HAZ);
        end
        tick();
        mem_memread = 1'b0;
        #4;
        tests_run++;
        if (outs !== O_TAKEN) begin
            tests_failed++;
            $display("FAIL br_resolve_flush: got %b want %b", outs, O_TAKEN);
        end
        tick();
        clear_inputs();
        id_branch = 1'b1; id_rs = 5'd2; id_rt = 5'd9; ex_regwrite = 1'b1; ex_rd = 5'd9;
        #4;
        tests_run++;
        if (outs !== O_HAZ) begin
            tests_failed++;
            $display("FAIL br_ex_stall: got %b want %b", outs, O_HAZ);
        end
        tick();
        id_branch = 1'b0;
        #4;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL nonbranch_regwrite: got %b want %b", outs, O_IDLE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_muldiv();
        logic [7:0] exp;
        md_start = 1'b1;
        #4;
        tests_run++;
        if (outs !== O_MD) begin
            tests_failed++;
            $display("FAIL md_issue: got %b want %b", outs, O_MD);
        end
        tick();
        md_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp = (k == 3) ? O_DONE : O_MD;
            #4;
            tests_run++;
            if (outs !== exp) begin
                tests_failed++;
                $display("FAIL md_cycle_%0d: got %b want %b", k, outs, exp);
            end
            tick();
        end
        #4;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL md_after: got %b want %b", outs, O_IDLE);
        end
        tick();
    endtask

    task automatic test_md_priority();
        logic [7:0] exp;
        md_start = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_taken = 1'b1;
        // md_start stays high through MD_WAIT and must be ignored there.
        for (int k = 0; k <= 3; k++) begin
            exp = (k == 3) ? O_DONE : O_MD;
            #4;
            tests_run++;
            if (outs !== exp) begin
                tests_failed++;
                $display("FAIL prio_cycle_%0d: got %b want %b", k, outs, exp);
            end
            tick();
        end
        md_start = 1'b0;
        #4;
        tests_run++;
        if (outs !== O_HAZ) begin
            tests_failed++;
            $display("FAIL prio_lu_after_done: got %b want %b", outs, O_HAZ);
        end
        tick();
        ex_memread = 1'b0;
        #4;
        tests_run++;
        if (outs !== O_TAKEN) begin
            tests_failed++;
            $display("FAIL prio_taken_after: got %b want %b", outs, O_TAKEN);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_md_reset();
        int done_seen;
        done_seen = 0;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (outs !== O_IDLE) begin
            tests_failed++;
            $display("FAIL md_reset_immediate: got %b want %b", outs, O_IDLE);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #4;
            if (md_done !== 1'b0 || md_busy !== 1'b0) done_seen++;
            tick();
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("FAIL md_reset_no_done: got %0d busy/done cycles want 0", done_seen);
        end
    endtask

    task automatic test_stall_count();
        do_reset();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        tick();
        #4;
`ifdef HAZARD_STALL_CNT_EN
        tests_run++;
        if (stall_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL stall_count_md: got %0d want 4", stall_count);
        end
`else
        tests_run++;
        if (stall_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL stall_count_tied: got %0d want 0", stall_count);
        end
`endif
        tick();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_md_priority();
        test_md_reset();
        test_stall_count();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
